// File: rtl/req_sequencer.sv
// Per-channel request sequencer: turns one-cycle transfer requests into
// registered arbiter requests, counts granted beats and pulses done per burst.
// Latency: request to r is one edge; done follows the completing edge by one cycle.
module req_sequencer #(
  parameter int BURST = 4,  // granted beats per transfer, 1..15
  parameter int DEPTH = 3   // pending transfers per channel, 1..3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:1] req_pulse,
  input  logic [3:1] g,
  output logic [3:1] r,
  output logic [3:1] done,
  output logic [3:1] ovf,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam logic [3:0] BURST_L = 4'(BURST);
  localparam logic [1:0] DEPTH_L = 2'(DEPTH);

  logic [3:1] w_stray;
  logic       w_multi;
  logic       r_err;

  // More than one grant bit high on the same edge is always a protocol error.
  assign w_multi = (g[1] & g[2]) | (g[1] & g[3]) | (g[2] & g[3]);

  for (genvar gi = 1; gi <= 3; gi++) begin : g_ch
    state_t     r_state;
    logic [1:0] r_pend;
    logic [3:0] r_beat;
    logic       r_req;
    logic       r_done;
    logic       r_ovf;

    logic       w_active;
    logic       w_cmpl;
    logic       w_inc;
    logic       w_drop;
    logic [3:0] w_beat_inc;
    logic [1:0] w_pend_nxt;

    // Only REQ and XFER hold r high, so only they may legally see a grant.
    assign w_active   = (r_state == S_REQ) || (r_state == S_XFER);
    // Beat count is zero in REQ, so this also covers BURST=1 completing there.
    assign w_beat_inc = r_beat + 4'd1;
    assign w_cmpl     = w_active && g[gi] && (w_beat_inc == BURST_L);
    // A request landing on a completion edge nets to zero even when full,
    // so it is accepted rather than dropped.
    assign w_inc      = req_pulse[gi] && ((r_pend != DEPTH_L) || w_cmpl);
    assign w_drop     = req_pulse[gi] && !w_inc;
    assign w_stray[gi] = g[gi] && !w_active;

    // Next pending count: increment, decrement, or both cancel out.
    always_comb begin
      w_pend_nxt = r_pend;
      if (w_inc && !w_cmpl) begin
        w_pend_nxt = r_pend + 2'd1;
      end else if (!w_inc && w_cmpl) begin
        w_pend_nxt = r_pend - 2'd1;
      end
    end

    // Channel FSM with pending/beat counters and registered r/done/ovf.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_state <= S_IDLE;
        r_pend  <= 2'd0;
        r_beat  <= 4'd0;
        r_req   <= 1'b0;
        r_done  <= 1'b0;
        r_ovf   <= 1'b0;
      end else begin
        r_pend <= w_pend_nxt;
        r_done <= w_cmpl;
        if (w_drop) begin
          r_ovf <= 1'b1;
        end
        case (r_state)
          S_IDLE: begin
            r_beat <= 4'd0;
            if (w_pend_nxt != 2'd0) begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_req   <= 1'b0;
            end
          end
          S_REQ, S_XFER: begin
            if (g[gi]) begin
              if (w_cmpl) begin
                r_state <= S_GAP;
                r_beat  <= 4'd0;
                r_req   <= 1'b0;
              end else begin
                r_state <= S_XFER;
                r_beat  <= w_beat_inc;
                r_req   <= 1'b1;
              end
            end else begin
              // Losing the grant mid-burst restarts the burst from zero beats.
              r_state <= S_REQ;
              r_beat  <= 4'd0;
              r_req   <= 1'b1;
            end
          end
          S_GAP: begin
            // One dead cycle lets lower-priority channels win arbitration.
            r_beat <= 4'd0;
            if (w_pend_nxt != 2'd0) begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_req   <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_beat  <= 4'd0;
            r_req   <= 1'b0;
          end
        endcase
      end
    end

    assign r[gi]    = r_req;
    assign done[gi] = r_done;
    assign ovf[gi]  = r_ovf;
  end

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_multi || (|w_stray)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;

endmodule

// File: tb/tb_req_sequencer.sv
// Bench for req_sequencer: directed scenarios, done pulses tracked by a scoreboard.
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
// Done pulses are checked on the falling edge against the expected-done queue.
module tb_req_sequencer;

  localparam int BURST = 4;

  logic       clk;
  logic       reset;
  logic [3:1] req_pulse;
  logic [3:1] g;
  logic [3:1] r;
  logic [3:1] done;
  logic [3:1] ovf;
  logic       err;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];

  req_sequencer #(.BURST(BURST), .DEPTH(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_pulse (req_pulse),
    .g         (g),
    .r         (r),
    .done      (done),
    .ovf       (ovf),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Grant channel ch for the given number of edges; a full burst queues a done.
  task automatic burst(input int ch, input int beats, input bit pulse_on_last);
    for (int b = 0; b < beats; b++) begin
      g = 3'(1 << (ch - 1));
      if (b == BURST - 1) begin
        exp_q.push_back(1 << (ch - 1));
        if (pulse_on_last) req_pulse = 3'(1 << (ch - 1));
      end
      step();
    end
    g = 3'b000;
    req_pulse = 3'b000;
  endtask

  // Every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (done != 3'b000) begin
      if (exp_q.size() == 0) begin
        chk("done_unexpected", int'(done), 0);
      end else begin
        chk("done_ch", int'(done), exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1;
    req_pulse = 3'b000;
    g = 3'b000;
    step();
    step();
    chk("rst_state", int'({r, done, ovf, err}), 0);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("idle", int'({r, done, ovf, err}), 0);
    end

    // Single four-beat transfer on channel 1.
    req_pulse = 3'b001;
    step();
    req_pulse = 3'b000;
    chk("t1_req", int'(r), 1);
    burst(1, 4, 1'b0);
    chk("t1_gap", int'(r), 0);
    step();
    chk("t1_idle", int'(r), 0);
    step();
    chk("t1_idle2", int'(r), 0);

    // Four requests on channel 2: the fourth overflows, three bursts drain it.
    for (int k = 0; k < 4; k++) begin
      req_pulse = 3'b010;
      step();
    end
    req_pulse = 3'b000;
    chk("t2_ovf", int'(ovf), 2);
    chk("t2_r", int'(r), 2);
    for (int k = 0; k < 3; k++) begin
      burst(2, 4, 1'b0);
      chk("t2_gap", int'(r), 0);
      step();
      chk("t2_after_gap", int'(r), (k < 2) ? 2 : 0);
    end
    chk("t2_ovf_sticky", int'(ovf), 2);
    chk("t2_no_err", int'(err), 0);

    // Multi-hot grant sets err; it stays set until reset.
    g = 3'b011;
    step();
    g = 3'b000;
    chk("err_multi", int'(err), 1);
    chk("stray_ignored", int'(r), 0);
    step();
    step();
    chk("err_sticky", int'(err), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("err_ovf_cleared", int'({ovf, err}), 0);

    // Grant to an idle channel 3 is a stray grant.
    g = 3'b100;
    step();
    g = 3'b000;
    chk("err_stray3", int'(err), 1);
    chk("stray3_ignored", int'(r), 0);
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Channel 1 preempted after two beats, then a full burst with a request
    // landing on the completion edge, then the second transfer.
    req_pulse = 3'b001;
    step();
    req_pulse = 3'b000;
    chk("t3_req", int'(r), 1);
    burst(1, 2, 1'b0);
    step();
    chk("t3_preempt", int'(r), 1);
    burst(1, 4, 1'b1);
    chk("t3_gap", int'(r), 0);
    step();
    chk("t3_rereq", int'(r), 1);
    burst(1, 4, 1'b0);
    chk("t3_gap2", int'(r), 0);
    step();
    chk("t3_idle", int'(r), 0);

    // Reset on beat 3 of a channel-3 transfer aborts it; request during reset ignored.
    req_pulse = 3'b100;
    step();
    req_pulse = 3'b000;
    chk("t7_req", int'(r), 4);
    g = 3'b100;
    step();
    step();
    reset = 1'b1;
    req_pulse = 3'b010;
    step();
    reset = 1'b0;
    req_pulse = 3'b000;
    g = 3'b000;
    chk("t7_r", int'(r), 0);
    chk("t7_done", int'(done), 0);
    chk("t7_flags", int'({ovf, err}), 0);
    step();
    step();
    chk("t7_pend0", int'(r), 0);
    step();

    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
